// File: rtl/dest_reg_tracker.sv
// dest_reg_tracker: decodes the destination register of the instruction in ID and shifts it EX -> MEM (-> WB).
// Latency: a tag decoded in cycle N is on reg_exe after edge N+1, on reg_mem after N+2 (reg_wb after N+3).
// Backpressure: stall, flush or an empty ID put a bubble (tag 0) into EX; MEM/WB are never held and always drain.
// Optional: define DEST_WB_TRACK_EN to add the registered WB tag output reg_wb and include it in pending.
module dest_reg_tracker #(
    parameter int          CNT_W  = 16,
    parameter int unsigned RA_REG = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ins,
    input  logic             id_valid,
    input  logic             stall,
    input  logic             flush,
    output logic [4:0]       reg_exe,
    output logic [4:0]       reg_mem,
    output logic [31:0]      pending,
    output logic [CNT_W-1:0] stall_cnt,
`ifdef DEST_WB_TRACK_EN
    output logic [4:0]       reg_wb,
`endif
    output logic             bubble
);

    // Opcodes that write a register
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [4:0]       dec_tag;
    logic [4:0]       ex_tag_d,    ex_tag_q;
    logic [4:0]       mem_tag_d,   mem_tag_q;
    logic             bubble_d,    bubble_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

    // rs and shamt never name a destination; the jal target is irrelevant here
    logic unused_ins;
    assign unused_ins = ^{ins[25:21], ins[10:6]};

    // Destination decode of the instruction sitting in ID; 0 means "no write"
    always_comb begin
        dec_tag = 5'd0;
        unique case (ins[31:26])
            OP_RTYPE: dec_tag = (ins[5:0] == FN_JR) ? 5'd0 : ins[15:11];
            OP_LW, OP_ADDI, OP_ADDIU, OP_SLTI,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                      dec_tag = ins[20:16];
            OP_JAL:   dec_tag = 5'(RA_REG);
            default:  dec_tag = 5'd0;
        endcase
    end

    // EX load: flush beats stall; an empty ID also becomes a bubble so ins is never looked at
    always_comb begin
        ex_tag_d = dec_tag;
        bubble_d = 1'b0;
        if (flush || stall || !id_valid) begin
            ex_tag_d = 5'd0;
            bubble_d = 1'b1;
        end
    end

    // MEM always takes whatever was in EX; a stall freezes only IF/ID
    always_comb begin
        mem_tag_d = ex_tag_q;
    end

    // Stall-cycle counter saturates at all-ones instead of wrapping
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    // Stage registers; reset discards every in-flight tag at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_tag_q    <= 5'd0;
            mem_tag_q   <= 5'd0;
            bubble_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            ex_tag_q    <= ex_tag_d;
            mem_tag_q   <= mem_tag_d;
            bubble_q    <= bubble_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

`ifdef DEST_WB_TRACK_EN
    logic [4:0] wb_tag_d, wb_tag_q;

    // WB follows MEM unconditionally
    always_comb begin
        wb_tag_d = mem_tag_q;
    end

    // WB tag register, kept for register files without write-before-read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_tag_q <= 5'd0;
        end else begin
            wb_tag_q <= wb_tag_d;
        end
    end

    assign reg_wb = wb_tag_q;
`endif

    // Pending bitmap: one-hot of every tracked stage, bit 0 ($0) never pending
    always_comb begin
        pending = (32'd1 << ex_tag_q) | (32'd1 << mem_tag_q);
`ifdef DEST_WB_TRACK_EN
        pending = pending | (32'd1 << wb_tag_q);
`endif
        pending[0] = 1'b0;
    end

    assign reg_exe   = ex_tag_q;
    assign reg_mem   = mem_tag_q;
    assign bubble    = bubble_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_dest_reg_tracker.sv
// Bench for dest_reg_tracker: directed steps, expected EX results queued at drive time, popped after the edge.
// Built with CNT_W=4 so stall-counter saturation is reachable in a few cycles.
// Optional WB tracking is checked when DEST_WB_TRACK_EN is defined.
module tb_dest_reg_tracker;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      ins;
    logic             id_valid;
    logic             stall;
    logic             flush;
    logic [4:0]       reg_exe;
    logic [4:0]       reg_mem;
    logic [31:0]      pending;
    logic [CNT_W-1:0] stall_cnt;
    logic             bubble;
`ifdef DEST_WB_TRACK_EN
    logic [4:0]       reg_wb;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Scoreboard entries: {bubble, ex_tag}
    logic [5:0] exp_q[$];

    // Reference pipeline state
    logic [4:0]       m_ex, m_mem, m_wb;
    logic             m_bub;
    logic [CNT_W-1:0] m_cnt;

    dest_reg_tracker #(.CNT_W(CNT_W), .RA_REG(31)) dut (
        .clk       (clk),
        .rst       (rst),
        .ins       (ins),
        .id_valid  (id_valid),
        .stall     (stall),
        .flush     (flush),
        .reg_exe   (reg_exe),
        .reg_mem   (reg_mem),
        .pending   (pending),
        .stall_cnt (stall_cnt),
`ifdef DEST_WB_TRACK_EN
        .reg_wb    (reg_wb),
`endif
        .bubble    (bubble)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Reference destination decode written from the instruction-set table
    function automatic logic [4:0] ref_dest(input logic [31:0] i);
        logic [5:0] op;
        op = i[31:26];
        if (op == 6'h00)      return (i[5:0] == 6'h08) ? 5'd0 : i[15:11];
        else if (op == 6'h23) return i[20:16];
        else if (op >= 6'h08 && op <= 6'h0f && op != 6'h0b) return i[20:16];
        else if (op == 6'h03) return 5'd31;
        else                  return 5'd0;
    endfunction

    function automatic logic [31:0] ref_pending();
        logic [31:0] p;
        p = 32'd0;
        for (int r = 1; r < 32; r++) begin
            if (m_ex == 5'(r) || m_mem == 5'(r)) p[r] = 1'b1;
`ifdef DEST_WB_TRACK_EN
            if (m_wb == 5'(r)) p[r] = 1'b1;
`endif
        end
        return p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".reg_exe"},   32'(reg_exe),   32'(m_ex));
        check({tag, ".reg_mem"},   32'(reg_mem),   32'(m_mem));
        check({tag, ".bubble"},    32'(bubble),    32'(m_bub));
        check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_cnt));
        check({tag, ".pending"},   pending,        ref_pending());
`ifdef DEST_WB_TRACK_EN
        check({tag, ".reg_wb"},    32'(reg_wb),    32'(m_wb));
`endif
    endtask

    task automatic model_reset();
        m_ex  = 5'd0;
        m_mem = 5'd0;
        m_wb  = 5'd0;
        m_bub = 1'b0;
        m_cnt = '0;
        exp_q.delete();
    endtask

    // Drive one cycle of stimulus, queue its expected EX result, compare after the edge
    task automatic step(input string tag, input logic [31:0] i, input logic v,
                        input logic s, input logic f);
        logic [5:0] e;
        ins      = i;
        id_valid = v;
        stall    = s;
        flush    = f;
        if (f || s || !v) exp_q.push_back({1'b1, 5'd0});
        else              exp_q.push_back({1'b0, ref_dest(i)});
        @(posedge clk);
        #1;
        e     = exp_q.pop_front();
        m_wb  = m_mem;
        m_mem = m_ex;
        m_ex  = e[4:0];
        m_bub = e[5];
        if (s && m_cnt != '1) m_cnt = m_cnt + 1'b1;
        check_state(tag);
    endtask

    initial begin
        logic [31:0] add3, add5, lw7, lw4, jal0, sw2, addi9, jr31, beq0, ori12, rd0;
        add3  = mk_r(5'd1, 5'd2, 5'd3, 6'h20);
        add5  = mk_r(5'd1, 5'd2, 5'd5, 6'h20);
        lw7   = mk_i(6'h23, 5'd1, 5'd7, 16'd0);
        lw4   = mk_i(6'h23, 5'd1, 5'd4, 16'd8);
        jal0  = {6'h03, 26'h0000400};
        sw2   = mk_i(6'h2b, 5'd1, 5'd2, 16'd0);
        addi9 = mk_i(6'h08, 5'd0, 5'd9, 16'd1);
        jr31  = mk_r(5'd31, 5'd0, 5'd0, 6'h08) | 32'h0000_f800;
        beq0  = mk_i(6'h04, 5'd1, 5'd2, 16'd4);
        ori12 = mk_i(6'h0d, 5'd3, 5'd12, 16'h00ff);
        rd0   = mk_r(5'd1, 5'd2, 5'd0, 6'h20);

        model_reset();
        rst      = 1'b1;
        ins      = add3;
        id_valid = 1'b1;
        stall    = 1'b1;
        flush    = 1'b0;

        // Reset held across edges with a valid instruction and stall asserted
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_state("reset");
        end
        stall = 1'b0;
        rst   = 1'b0;

        // Decode sequence: EX 5, 7, 31, 0 with MEM one behind
        step("dec_add5", add5, 1'b1, 1'b0, 1'b0);
        check("dec_add5.exe_const", 32'(reg_exe), 32'd5);
        step("dec_lw7", lw7, 1'b1, 1'b0, 1'b0);
        check("dec_lw7.pending_const", pending, 32'h0000_00a0);
        step("dec_jal", jal0, 1'b1, 1'b0, 1'b0);
        check("dec_jal.exe_const", 32'(reg_exe), 32'd31);
        check("dec_jal.mem_const", 32'(reg_mem), 32'd7);
        step("dec_sw", sw2, 1'b1, 1'b0, 1'b0);
        check("dec_sw.exe_const", 32'(reg_exe), 32'd0);

        // Stall bubbles: EX empty for two cycles while MEM drains
        step("stall1", lw4, 1'b1, 1'b1, 1'b0);
        step("stall2", lw4, 1'b1, 1'b1, 1'b0);
        check("stall2.cnt_const", 32'(stall_cnt), 32'd2);
        step("stall_rel", lw4, 1'b1, 1'b0, 1'b0);

        // Non-writing and corner encodings, empty ID with undriven ins
        step("jr", jr31, 1'b1, 1'b0, 1'b0);
        step("beq", beq0, 1'b1, 1'b0, 1'b0);
        step("rd0", rd0, 1'b1, 1'b0, 1'b0);
        step("ori12", ori12, 1'b1, 1'b0, 1'b0);
        step("empty_id", 32'hxxxx_xxxx, 1'b0, 1'b0, 1'b0);
        check("empty_id.exe_const", 32'(reg_exe), 32'd0);

        // Flush beats stall; stall still counted
        step("flush_stall", addi9, 1'b1, 1'b1, 1'b1);
        check("flush_stall.cnt_const", 32'(stall_cnt), 32'd3);
        step("flush_only", addi9, 1'b1, 1'b0, 1'b1);

        // Same tag in EX and MEM keeps the pending bit until both drain
        step("dup_a", addi9, 1'b1, 1'b0, 1'b0);
        step("dup_b", addi9, 1'b1, 1'b0, 1'b0);
        step("dup_drain1", sw2, 1'b1, 1'b0, 1'b0);
        check("dup_drain1.pending_const", pending, 32'h0000_0200);
        step("dup_drain2", sw2, 1'b1, 1'b0, 1'b0);

        // Saturation of the 4-bit stall counter
        for (int k = 0; k < 20; k++) step("sat", lw4, 1'b1, 1'b1, 1'b0);
        check("sat.cnt_const", 32'(stall_cnt), 32'd15);

        // Mid-flight asynchronous reset with EX=5, MEM=7
        step("pre_rst_lw7", lw7, 1'b1, 1'b0, 1'b0);
        step("pre_rst_add5", add5, 1'b1, 1'b0, 1'b0);
        check("pre_rst.exe_const", 32'(reg_exe), 32'd5);
        check("pre_rst.mem_const", 32'(reg_mem), 32'd7);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_state("async_rst");
        #2;
        rst = 1'b0;

        // First edge after reset loads EX normally; WB sees it two edges later
        step("post_rst_add5", add5, 1'b1, 1'b0, 1'b0);
        check("post_rst.exe_const", 32'(reg_exe), 32'd5);
        step("wb_a", sw2, 1'b1, 1'b0, 1'b0);
        step("wb_b", sw2, 1'b1, 1'b0, 1'b0);
`ifdef DEST_WB_TRACK_EN
        check("wb_b.reg_wb_const", 32'(reg_wb), 32'd5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dest_reg_tracker.md
Name: dest_reg_tracker

Overview:
- Producer side of the pipeline hazard interface. Decodes the destination register of the instruction leaving ID and shifts that tag down EX → MEM (→ WB) stage registers.
- Drives reg_exe / reg_mem, which the hazard/stall unit compares against the source fields of the instruction in ID.
- Consumes that unit's stall output: on stall it inserts a bubble.
- Also keeps a pending-register bitmap and a saturating stall-cycle counter for debug/perf.

Parameters:
- CNT_W, 16, width of the stall-cycle counter
- RA_REG, 31, destination register number for jal

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- ins  input  32  instruction currently in ID
- id_valid  input  1  ins holds a real instruction (0 = ID empty)
- stall  input  1  hazard unit stall request for this cycle
- flush  input  1  taken branch/jump; squash the instruction in ID
- reg_exe  output  5  destination tag in EX; 0 = no write
- reg_mem  output  5  destination tag in MEM; 0 = no write
- pending  output  32  bit r set when any tracked stage holds tag r; bit 0 always 0
- stall_cnt  output  CNT_W  saturating count of cycles with stall=1
- bubble  output  1  registered; 1 when EX currently holds an inserted bubble

Behaviour:
- Reset (asynchronous, immediate, independent of clk):
  - reg_exe = reg_mem = 0; WB tag = 0
  - pending = 0; stall_cnt = 0; bubble = 0
- Destination decode (combinational on ins[31:26]):
  - 000000 → rd = ins[15:11], except funct 001000 (jr) → 0
  - 100011 (lw), 001000, 001001, 001010, 001100, 001101, 001110, 001111 → rt = ins[20:16]
  - 000011 (jal) → RA_REG
  - anything else (sw, beq, bne, j, ...) → 0
  - A decoded tag of 0 is "no write"; $0 is never reported as pending.
- EX stage update, each rising clk, in priority order:
  - flush=1 → EX tag = 0, bubble = 1 (flush beats stall)
  - else stall=1 or id_valid=0 → EX tag = 0, bubble = 1
  - else → EX tag = decoded tag, bubble = 0
- MEM and WB stages:
  - MEM tag <= EX tag every cycle, never held. A stall freezes only IF/ID; instructions already in EX drain forward.
  - WB tag <= MEM tag (internal unless the optional feature is enabled).
- Latency:
  - A tag decoded in cycle N appears on reg_exe after edge N+1 and on reg_mem after edge N+2.
  - A lw followed immediately by a dependent op therefore sees reg_exe match → stall. The next cycle it sees reg_mem match → stall. It is released on the third cycle.
- pending:
  - Combinational OR of one-hot decodes of the EX and MEM tags (plus WB when enabled), with bit 0 masked.
  - If two stages hold the same tag, the bit stays set until both have drained.
- stall_cnt:
  - Increments on each edge where stall=1.
  - Saturates at all-ones and never wraps.
  - Cleared only by rst.
- Reset mid-operation: all in-flight tags are discarded immediately; the first edge after rst deasserts loads EX normally.
- No X propagation: when id_valid=0 the value of ins is don't-care.

Optional Feature:
- Macro: DEST_WB_TRACK_EN
- Defined:
  - Adds output port reg_wb (output, 5), the registered WB tag.
  - pending also includes the WB tag.
  - This supports register files without write-before-read.
- Undefined:
  - No reg_wb port; the WB register is not instantiated.
  - pending covers EX and MEM only.

Test Plan:
- Reset: hold rst=1 with ins = add $3,$1,$2 and id_valid=1 across edges → reg_exe=0, reg_mem=0, pending=0, stall_cnt=0 throughout.
- Decode: drive add $5,$1,$2 (rd=5), then lw $7,0($1), then jal, then sw, one per cycle with stall=0, flush=0 →
  - reg_exe sequence 5, 7, 31, 0
  - reg_mem lags by one cycle
  - pending=0x000000A0 in the cycle with EX=7, MEM=5
- Stall bubble: hold ins = lw $4,... and raise stall=1 for 2 cycles → reg_exe=0 and bubble=1 for 2 cycles; stall_cnt=2; reg_mem drains the prior tag and then becomes 0.
- Flush priority: stall=1 and flush=1 together with ins = addi $9,$0,1 → reg_exe=0 after the edge; stall_cnt still increments by 1.
- Saturation: with CNT_W=4, hold stall=1 for 20 cycles → stall_cnt reaches 15 and stays 15.
- Reset mid-flight and option:
  - With EX=5, MEM=7, assert rst asynchronously between edges → both read 0 before the next edge.
  - With DEST_WB_TRACK_EN defined, the instruction that sets reg_exe=5 gives reg_wb=5 two edges later.
